// File: rtl/cmos_pkg.sv
// Shared constants, state encoding and sizing helper for the CMOS frame packer.
package cmos_pkg;

    localparam int PIX_PER_WORD   = 8;
    localparam int BYTES_PER_WORD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DROP = 2'd2
    } state_e;

    function automatic int words_per_frame(input int h, input int v);
        return (h * v) / PIX_PER_WORD;
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Ping-pong bank selection, per-frame word index and byte-address generation,
// plus the frame_done pulse raised when the closing word is accepted.
module frame_addr_gen
    import cmos_pkg::*;
#(
    parameter int                ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = '0,
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(32'h0020_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              word_load,
    input  logic              last_accept,
    output logic [ADDR_W-1:0] word_addr,
    output logic              frame_bank,
    output logic              frame_done
);

    localparam int OFS_W = $clog2(BYTES_PER_WORD);
    localparam int IDX_W = ADDR_W - OFS_W;

    logic [IDX_W-1:0] widx_q, widx_d, widx_cur;
    logic             bank_q, bank_d;
    logic             done_q, done_d;

    // A start-of-frame pixel may itself close a word, so it must see index 0.
    always_comb begin
        widx_cur = frame_start ? '0 : widx_q;
        widx_d   = widx_q;
        if (word_load) begin
            widx_d = widx_cur + IDX_W'(1);
        end else if (frame_start) begin
            widx_d = '0;
        end
        bank_d    = bank_q ^ last_accept;
        done_d    = last_accept;
        word_addr = (bank_q ? FRAME_BASE1 : FRAME_BASE0) + {widx_cur, {OFS_W{1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_q <= '0;
            bank_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            widx_q <= widx_d;
            bank_q <= bank_d;
            done_q <= done_d;
        end
    end

    assign frame_bank = bank_q;
    assign frame_done = done_q;

endmodule

// File: rtl/cmos_frame_packer.sv
// Packs RGB565 pixels eight to a 128-bit word and hands them, with a frame-buffer
// byte address, to the DDR write FIFO; flags overflow and malformed frames.
module cmos_frame_packer
    import cmos_pkg::*;
#(
    parameter int                H_DISP      = 1280,
    parameter int                V_DISP      = 720,
    parameter int                ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = '0,
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(32'h0020_0000)
) (
    input  logic              cmos_pclk,
    input  logic              sys_rst,
    input  logic [15:0]       pix_data,
    input  logic              pix_valid,
    input  logic              pix_sop,
    input  logic              pix_eop,
    output logic [127:0]      wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              wr_last,
    output logic              frame_done,
    output logic              frame_bank,
    output logic              overflow,
    output logic              len_err
);

    localparam int          IDX_W     = $clog2(PIX_PER_WORD);
    localparam logic [20:0] FRAME_PIX = 21'(H_DISP * V_DISP);
    localparam logic [20:0] CNT_MAX   = '1;

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_cur;
    logic [PIX_PER_WORD-1:0][15:0] lanes_q, lanes_d, lanes_base, word_lanes;
    logic [20:0] cnt_q, cnt_d, cnt_cur;
    logic [127:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, word_addr;
    logic wr_valid_q, wr_valid_d, wr_last_q, wr_last_d;
    logic overflow_q, overflow_d, len_err_q, len_err_d;
    logic start, take, complete, ovf_evt, load, accept, last_accept;

    assign start       = pix_valid & pix_sop;
    assign take        = start | (pix_valid & (state_q == PACK));
    assign idx_cur     = start ? '0 : idx_q;
    assign lanes_base  = start ? '0 : lanes_q;
    assign complete    = take & ((idx_cur == IDX_W'(PIX_PER_WORD - 1)) | pix_eop);
    assign accept      = wr_valid_q & wr_ready;
    assign ovf_evt     = complete & wr_valid_q & ~wr_ready;
    assign load        = complete & ~ovf_evt;
    assign last_accept = accept & wr_last_q;

    // Lanes above the current index stay zero, which gives the eop padding for free.
    genvar gi;
    generate
        for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
            assign word_lanes[gi] = (idx_cur == IDX_W'(gi)) ? pix_data : lanes_base[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lanes_d    = lanes_q;
        cnt_d      = cnt_q;
        len_err_d  = len_err_q;
        overflow_d = overflow_q;
        cnt_cur    = start ? 21'd1 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 21'd1);
        if (take) begin
            cnt_d = cnt_cur;
            if (start && (state_q == PACK)) begin
                len_err_d = 1'b1;
            end
            if (pix_eop && (cnt_cur != FRAME_PIX)) begin
                len_err_d = 1'b1;
            end
            if (ovf_evt) begin
                overflow_d = 1'b1;
                state_d    = DROP;
                idx_d      = '0;
                lanes_d    = '0;
            end else if (pix_eop) begin
                state_d = IDLE;
                idx_d   = '0;
                lanes_d = '0;
            end else if (complete) begin
                state_d = PACK;
                idx_d   = '0;
                lanes_d = '0;
            end else begin
                state_d = PACK;
                idx_d   = idx_cur + IDX_W'(1);
                lanes_d = word_lanes;
            end
        end
    end

    // A load in the same cycle as an accept keeps wr_valid high with the new word.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        wr_last_d  = wr_last_q;
        if (load) begin
            wr_valid_d = 1'b1;
            wr_data_d  = word_lanes;
            wr_addr_d  = word_addr;
            wr_last_d  = pix_eop;
        end else if (accept) begin
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
        end
    end

    always_ff @(posedge cmos_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            lanes_q    <= '0;
            cnt_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= FRAME_BASE0;
            wr_last_q  <= 1'b0;
            overflow_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lanes_q    <= lanes_d;
            cnt_q      <= cnt_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_last_q  <= wr_last_d;
            overflow_q <= overflow_d;
            len_err_q  <= len_err_d;
        end
    end

    frame_addr_gen #(
        .ADDR_W      (ADDR_W),
        .FRAME_BASE0 (FRAME_BASE0),
        .FRAME_BASE1 (FRAME_BASE1)
    ) u_addr_gen (
        .clk         (cmos_pclk),
        .rst         (sys_rst),
        .frame_start (start),
        .word_load   (load),
        .last_accept (last_accept),
        .word_addr   (word_addr),
        .frame_bank  (frame_bank),
        .frame_done  (frame_done)
    );

    assign wr_data  = wr_data_q;
    assign wr_addr  = wr_addr_q;
    assign wr_valid = wr_valid_q;
    assign wr_last  = wr_last_q;
    assign overflow = overflow_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Scoreboard bench: a pixel-list reference model predicts words, flags and bank
// changes; a negedge monitor pops predictions whenever a word is handed over.
module tb_cmos_frame_packer;

    localparam int H  = 16;
    localparam int V  = 2;
    localparam int AW = 28;
    localparam int FP = H * V;
    localparam logic [AW-1:0] B0 = 28'h000_0000;
    localparam logic [AW-1:0] B1 = 28'h020_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   pix_data = '0;
    logic          pix_valid = 1'b0, pix_sop = 1'b0, pix_eop = 1'b0;
    logic [127:0]  wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid, wr_ready = 1'b0, wr_last;
    logic          frame_done, frame_bank, overflow, len_err;

    always #5 clk = ~clk;

    cmos_frame_packer #(
        .H_DISP(H), .V_DISP(V), .ADDR_W(AW), .FRAME_BASE0(B0), .FRAME_BASE1(B1)
    ) dut (
        .cmos_pclk(clk), .sys_rst(rst),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eop(pix_eop),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_last(wr_last), .frame_done(frame_done), .frame_bank(frame_bank),
        .overflow(overflow), .len_err(len_err)
    );

    typedef struct {
        logic [127:0]  data;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    bit          m_in_frame = 0;
    logic [15:0] m_cur[$];
    int          m_cnt = 0, m_widx = 0, m_done_exp = 0;
    bit          m_bank = 0, m_slot_full = 0, m_slot_last = 0, m_ovf = 0, m_len = 0;

    // Monitor state
    int            done_seen = 0;
    bit            hold_v = 0, first_seen = 0;
    logic [127:0]  hold_d, first_word = '0;
    logic [AW-1:0] hold_a;
    logic          hold_l;
    exp_t          mon_e;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pack_cur();
        logic [127:0] w = '0;
        for (int i = 0; i < m_cur.size(); i++) w[16*i +: 16] = m_cur[i];
        return w;
    endfunction

    // Predicts what happens at the clock edge that will sample these inputs.
    task automatic model_step(input bit v, input logic [15:0] d, input bit s, input bit e, input bit r);
        bit   acc, acc_last, comp;
        exp_t ex;
        acc      = m_slot_full && r;
        acc_last = acc && m_slot_last;
        comp     = 0;
        if (v) begin
            if (s) begin
                if (m_in_frame) m_len = 1;
                m_in_frame = 1;
                m_cur.delete();
                m_cnt  = 0;
                m_widx = 0;
            end
            if (m_in_frame) begin
                m_cur.push_back(d);
                m_cnt++;
                if (m_cur.size() == 8 || e) begin
                    comp    = 1;
                    ex.data = pack_cur();
                    ex.addr = (m_bank ? B1 : B0) + AW'(16 * m_widx);
                    ex.last = e;
                    m_cur.delete();
                end
                if (e) begin
                    if (m_cnt != FP) m_len = 1;
                    m_in_frame = 0;
                end
            end
        end
        if (comp && m_slot_full && !r) begin
            m_ovf      = 1;
            m_in_frame = 0;
            m_cur.delete();
        end else if (comp) begin
            exp_q.push_back(ex);
            m_widx++;
            m_slot_full = 1;
            m_slot_last = ex.last;
        end else if (acc) begin
            m_slot_full = 0;
        end
        if (acc_last) begin
            m_bank = !m_bank;
            m_done_exp++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cur.delete();
        m_in_frame = 0; m_cnt = 0; m_widx = 0; m_bank = 0;
        m_slot_full = 0; m_slot_last = 0; m_ovf = 0; m_len = 0;
    endtask

    task automatic cyc(input bit v, input logic [15:0] d, input bit s, input bit e, input bit r);
        @(posedge clk);
        #1;
        pix_valid = v; pix_data = d; pix_sop = s; pix_eop = e; wr_ready = r;
        model_step(v, d, s, e, r);
    endtask

    task automatic settle_and_check(input string tag);
        repeat (3) cyc(0, 16'h0, 0, 0, 1);
        check({tag, "_bank"},     160'(frame_bank),   160'(m_bank));
        check({tag, "_overflow"}, 160'(overflow),     160'(m_ovf));
        check({tag, "_len_err"},  160'(len_err),      160'(m_len));
        check({tag, "_done_cnt"}, 160'(done_seen),    160'(m_done_exp));
        check({tag, "_pending"},  160'(exp_q.size()), 160'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_valid"},   160'(wr_valid),   160'(0));
        check({tag, "_wr_data"},    160'(wr_data),    160'(0));
        check({tag, "_wr_addr"},    160'(wr_addr),    160'(B0));
        check({tag, "_wr_last"},    160'(wr_last),    160'(0));
        check({tag, "_frame_done"}, 160'(frame_done), 160'(0));
        check({tag, "_frame_bank"}, 160'(frame_bank), 160'(0));
        check({tag, "_overflow"},   160'(overflow),   160'(0));
        check({tag, "_len_err"},    160'(len_err),    160'(0));
    endtask

    function automatic bit rand_ready();
        return $urandom_range(0, 3) != 0;
    endfunction

    // Monitor: pops one prediction per handshake and checks held words stay stable.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) done_seen++;
            if (hold_v && wr_valid) begin
                check("hold_data", 160'(wr_data), 160'(hold_d));
                check("hold_addr", 160'(wr_addr), 160'(hold_a));
                check("hold_last", 160'(wr_last), 160'(hold_l));
            end
            hold_v = wr_valid && !wr_ready;
            hold_d = wr_data;
            hold_a = wr_addr;
            hold_l = wr_last;
            if (wr_valid && wr_ready) begin
                if (!first_seen) begin
                    first_seen = 1;
                    first_word = wr_data;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got addr %0h data %0h, required no word", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 160'(wr_data), 160'(mon_e.data));
                    check("word_addr", 160'(wr_addr), 160'(mon_e.addr));
                    check("word_last", 160'(wr_last), 160'(mon_e.last));
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_hold");
        rst = 1'b0;
        cyc(0, 16'h0, 0, 0, 1);
        check_outputs_zero("reset_release");

        // Full frame, counting pixels, every other cycle
        for (int i = 0; i < FP; i++) begin
            cyc(1, 16'(i), i == 0, i == FP - 1, 1);
            cyc(0, 16'h0, 0, 0, 1);
        end
        settle_and_check("frameA");
        check("frameA_first_word", 160'(first_word), 160'(128'h0007_0006_0005_0004_0003_0002_0001_0000));
        check("frameA_bank_now1", 160'(frame_bank), 160'(1));

        // Second frame lands in bank 1 and toggles back
        for (int i = 0; i < FP; i++) begin
            if ($urandom_range(0, 1) == 0) cyc(0, 16'h0, 0, 0, 1);
            cyc(1, 16'($urandom), i == 0, i == FP - 1, 1);
        end
        settle_and_check("frameB");

        // Short frame: eop on the 13th pixel
        for (int i = 0; i < 13; i++) cyc(1, 16'(16'h100 + i), i == 0, i == 12, 1);
        settle_and_check("short");

        // Backpressure across two completions
        for (int i = 0; i < 20; i++) cyc(1, 16'(16'h200 + i), i == 0, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        check("ovf_flag", 160'(overflow), 160'(1));
        check("ovf_held_valid", 160'(wr_valid), 160'(1));
        for (int i = 20; i < FP; i++) cyc(1, 16'(16'h200 + i), 0, i == FP - 1, 0);
        settle_and_check("ovf_drain");
        for (int i = 0; i < FP; i++) cyc(1, 16'(16'h300 + i), i == 0, i == FP - 1, 1);
        settle_and_check("ovf_next");

        // Reset mid-frame while a word is held
        for (int i = 0; i < 11; i++) cyc(1, 16'(16'h400 + i), i == 0, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        check("pre_reset_valid", 160'(wr_valid), 160'(1));
        #3 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        model_reset();
        repeat (2) cyc(0, 16'h0, 0, 0, 1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc(1, 16'(16'h500 + i), 0, i == 9, 1);
        settle_and_check("post_reset");

        // sop injected at pixel 10
        for (int i = 0; i < 10; i++) cyc(1, 16'(16'h600 + i), i == 0, 0, 1);
        for (int i = 0; i < FP; i++) cyc(1, 16'(16'h700 + i), i == 0, i == FP - 1, 1);
        settle_and_check("mid_sop");
        check("mid_sop_len_err", 160'(len_err), 160'(1));

        // Randomized frames, random backpressure, stray pixels between frames
        for (int f = 0; f < 40; f++) begin
            int len;
            bit drop_eop;
            len      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : FP;
            drop_eop = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < len; i++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) cyc(0, 16'h0, 0, 0, rand_ready());
                cyc(1, 16'($urandom), i == 0, (i == len - 1) && !drop_eop, rand_ready());
            end
            if ($urandom_range(0, 4) == 0)
                cyc(1, 16'($urandom), 0, $urandom_range(0, 1) == 1, rand_ready());
        end
        settle_and_check("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmos_frame_packer.md
Name: cmos_frame_packer

Overview:
- Consumes the 16-bit RGB565 pixel stream from the CMOS capture stage: pixel data, valid, and frame start/end markers.
- Packs 8 pixels into one 128-bit word and emits each word with a byte address into a ping-pong pair of frame buffers.
- Feeds the DDR write FIFO over a valid/ready handshake.
- Detects backpressure overflow and malformed frames, and resynchronises on the next frame start.

Parameters:
- H_DISP, 1280, active pixels per line.
- V_DISP, 720, active lines per frame.
- ADDR_W, 28, byte-address width.
- FRAME_BASE0, 28'h000_0000, byte base of bank 0.
- FRAME_BASE1, 28'h020_0000, byte base of bank 1.

Ports:
- cmos_pclk  in  1  pixel clock; the only clock.
- sys_rst  in  1  asynchronous reset, active-high.
- pix_data  in  16  RGB565 pixel.
- pix_valid  in  1  pixel strobe.
- pix_sop  in  1  first pixel of frame; aligned with pix_valid.
- pix_eop  in  1  last pixel of frame; aligned with pix_valid.
- wr_data  out  128  packed word; pixel 0 in [15:0], pixel 7 in [127:112].
- wr_addr  out  ADDR_W  byte address of wr_data.
- wr_valid  out  1  word available.
- wr_ready  in  1  sink accepts the word.
- wr_last  out  1  last word of frame; qualified by wr_valid.
- frame_done  out  1  one-cycle pulse when the wr_last word is accepted.
- frame_bank  out  1  bank currently being written.
- overflow  out  1  sticky; a word completed while the output register was still occupied.
- len_err  out  1  sticky; the frame did not carry exactly H_DISP*V_DISP pixels.

Behaviour:
- Reset values:
  - All outputs are 0; wr_addr is FRAME_BASE0.
  - State is IDLE, pixel index 0, pixel count 0.
  - Reset mid-frame discards the partial word and any held word. No frame_done is issued.
- States:
  - IDLE: ignore pixels until pix_valid & pix_sop. That pixel goes to lane 0, pixel count becomes 1, next state is PACK.
  - PACK: each pix_valid writes pix_data to lane idx, then idx increments mod 8.
  - DROP: ignore pixels until pix_valid & pix_sop, then behave exactly as the IDLE exit.
- Word completion:
  - A word completes when lane 7 is written, or when pix_eop is seen with the lane partially filled. Unused lanes are zero-padded.
  - The cycle after completion: the output register loads, wr_valid=1, and wr_last=1 if the word closes on pix_eop.
  - Latency is 1 cycle from the completing pixel to wr_valid.
- Output register rules:
  - wr_data, wr_addr and wr_last hold stable while wr_valid & !wr_ready.
  - On accept (wr_valid & wr_ready) wr_valid clears, unless a new word loads in the same cycle; in that case wr_valid stays 1 with the new contents.
- Overflow:
  - Trigger: a word completes while wr_valid=1 and wr_ready=0.
  - Response: set overflow, discard the new word, go to DROP, clear idx.
  - The held word is still delivered. The next frame reuses the same bank and restarts at its base; the bank does not toggle.
- Addressing:
  - Word address = bank base + 16*word index.
  - Word index resets to 0 at each sop and increments on each word load.
  - Words per full frame = H_DISP*V_DISP/8 (115200 at defaults). The last address is base + 0x1C1FF0.
- Frame end:
  - On accept of the wr_last word: frame_done pulses for 1 cycle, and frame_bank toggles in the same cycle.
  - The next sop uses the new bank.
- Length check:
  - At pix_eop, len_err is set if pixel count != H_DISP*V_DISP.
  - The frame is still terminated with wr_last and completes normally.
  - The pixel counter is 21 bits and saturates.
- Mid-frame sop (sop in PACK):
  - Set len_err and discard the partial word.
  - The sop pixel starts a new frame in lane 0 at the current bank base.
- pix_sop & pix_eop together: a 1-pixel frame. One padded word with wr_last=1 is emitted, and len_err is set unless H_DISP*V_DISP=1.
- pix_eop in IDLE/DROP: ignored, no flag.
- Sticky flags clear only on sys_rst.

Decomposition:
- Package cmos_pkg holds:
  - constant PIX_PER_WORD=8;
  - constant BYTES_PER_WORD=16;
  - the state enum {IDLE, PACK, DROP};
  - function words_per_frame(H,V).
- One natural sub-module: frame_addr_gen. It holds the bank toggle, the word index and address generation, and the frame_done pulse.
- Packing, the state machine and the output register stay in the top.

Test Plan:
- Full frame, H_DISP=16/V_DISP=2, pixels 0x0000..0x001F every other cycle, wr_ready=1:
  - 4 words at addrs 0x0,0x10,0x20,0x30;
  - word0 = 0x0007_0006_..._0000;
  - wr_last on the 4th word, frame_done 1 cycle after its accept, frame_bank becomes 1, no flags.
- Second frame after the first: addresses start at FRAME_BASE1 and frame_bank returns to 0 after it.
- Short frame, eop on the 13th pixel:
  - 2 words, the second has lanes 5..7 zero and wr_last=1;
  - len_err=1, frame_done still pulses.
- wr_ready=0 held across two word completions:
  - first word stays stable;
  - overflow=1, state DROP, no wr_last;
  - after wr_ready, the next sop restarts at the same bank base.
- sop injected at pixel 10 of a frame:
  - len_err=1, the partial word is dropped;
  - the new frame's first word is at the bank base with lane 0 = the sop pixel.
- Assert sys_rst mid-frame with wr_valid=1:
  - all outputs 0 immediately;
  - after release, pixels are ignored until the next sop.
